fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage ARM pipeline. Sits directly upstream of decode.
- Driven by the hazard unit's StallF/StallD/FlushD and by the EX/WB redirect sources.
- Owns the PC register, next-PC selection, the instruction-memory address and the registered InstrD/PCPlus8D/ValidD handed to decode.
- Keeps saturating stall/flush event counters for debug.

Parameters:
WIDTH, 32, datapath and address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of debug event counters

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
InstrF  input  WIDTH  instruction read combinationally from imem at PCF
StallF  input  1  hold PC register
StallD  input  1  hold IF/ID register
FlushD  input  1  clear IF/ID register to bubble
BranchTakenE  input  1  branch resolved taken in EX
ALUResultE  input  WIDTH  branch target from EX
PCSrcW  input  1  WB stage writes PC (R15 write)
ResultW  input  WIDTH  PC value from WB
PCF  output  WIDTH  fetch address to imem
InstrD  output  WIDTH  registered instruction for decode
PCPlus8D  output  WIDTH  PCF+8 of the fetched instruction (R15 read value)
ValidD  output  1  InstrD holds a real instruction
AlignErr  output  1  sticky: a redirect target had bits[1:0] != 0
StallCnt  output  CNT_W  cycles with StallF=1 and no redirect
FlushCnt  output  CNT_W  cycles with FlushD=1

Behaviour:
- Reset (async, reset_n=0) sets:
  - PCF=RESET_PC, InstrD=0, PCPlus8D=0, ValidD=0, AlignErr=0, StallCnt=0, FlushCnt=0.
  - Release is taken on a clock edge. The first fetch of RESET_PC occurs in the cycle after release.
- Next-PC priority, evaluated each cycle:
  1. BranchTakenE=1: PCnext = {ALUResultE[WIDTH-1:2],2'b00}.
  2. Else PCSrcW=1: PCnext = {ResultW[WIDTH-1:2],2'b00}.
  3. Else StallF=0: PCnext = PCF+4, wrapping modulo 2^WIDTH.
  4. Else PCF holds.
- Redirects override StallF. A taken branch or a WB PC write always updates PCF at the next edge.
- A redirect target with bits[1:0] != 0 sets AlignErr at the same edge. AlignErr clears only on reset.
- IF/ID register update at each edge, in priority order:
  - FlushD=1: InstrD=0, PCPlus8D=0, ValidD=0. Flush wins over StallD.
  - Else StallD=1: InstrD, PCPlus8D and ValidD hold.
  - Else: InstrD=InstrF, PCPlus8D=PCF+8 (modulo 2^WIDTH), ValidD=1.
- StallF=1 with StallD=0 and FlushD=0 (control-hazard stall) still loads IF/ID normally. The hazard unit co-asserts FlushD in that case, so the register becomes a bubble.
- Latency: the instruction at PCF appears on InstrD one cycle later. A redirect is visible on PCF one cycle after BranchTakenE/PCSrcW.
- Simultaneous BranchTakenE and PCSrcW: the branch target wins; the ResultW value is discarded.
- StallCnt increments when StallF=1 and no redirect is active. FlushCnt increments when FlushD=1. Both saturate at 2^CNT_W-1.
- Reset asserted mid-operation clears everything immediately, independent of clk.
- No combinational path from any input to PCF. All outputs are registered.

Decomposition:
- Shared package arm_pipe_pkg holds:
  - BUBBLE_INSTR (32'h0)
  - RESET_PC default
  - PC_STEP (4)
  - PC_READ_OFFSET (8)
- Sub-module pipe_reg: parameterised width, async active-low reset, synchronous clear and enable, clear over enable. It is instantiated for the IF/ID fields and reused later for the ID/EX, EX/MEM and MEM/WB registers.

Test Plan:
- Reset then 4 free-running cycles, InstrF=32'hE280_1001 -> PCF 0,4,8,12. InstrD=E2801001 from cycle 2 with ValidD=1. PCPlus8D=8,12,16.
- StallF=1 and StallD=1 for 2 cycles at PCF=8 -> PCF holds 8. InstrD/PCPlus8D hold. StallCnt=2.
- BranchTakenE=1, ALUResultE=32'h100, FlushD=1 -> next PCF=0x100, ValidD=0, InstrD=0, FlushCnt increments. The following cycle fetches 0x100 and PCPlus8D=0x108.
- BranchTakenE=1 (0x200) together with PCSrcW=1 (0x300) and StallF=1 -> PCF=0x200. StallCnt does not increment.
- PCSrcW=1, ResultW=32'h0000_0402 -> PCF=0x400 and AlignErr=1, and AlignErr stays 1 until reset_n is pulsed low mid-cycle, which clears all outputs asynchronously.
- PCF=32'hFFFF_FFFC, no stall -> wraps to 0 next cycle. PCPlus8D=32'h0000_0004. Hold StallF for 2^CNT_W+5 cycles -> StallCnt saturates at all-ones.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared constants for the 5-stage ARM pipeline.
// Holds the bubble encoding, the reset PC default and the PC arithmetic steps.
package arm_pipe_pkg;

    localparam logic [31:0] BUBBLE_INSTR   = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DFLT  = 32'h0000_0000;
    localparam int          PC_STEP        = 4;
    localparam int          PC_READ_OFFSET = 8;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: 1-cycle latency, clear beats enable, enable low holds.
// Reused for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= CLR_VAL;
        end else if (clr_i) begin
            data_q <= CLR_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: PC select, imem address, registered decode inputs.
// 1-cycle latency to decode; StallF/StallD hold, FlushD inserts a bubble, redirects beat StallF.
module fetch_stage
    import arm_pipe_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DFLT),
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] InstrF,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             BranchTakenE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic             PCSrcW,
    input  logic [WIDTH-1:0] ResultW,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCPlus8D,
    output logic             ValidD,
    output logic             AlignErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int IFID_W = 2 * WIDTH + 1;
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {1'b0, {WIDTH{1'b0}}, WIDTH'(BUBBLE_INSTR)};

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             align_q, align_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             redirect;
    logic [WIDTH-1:0] redirect_tgt;
    logic [IFID_W-1:0] ifid_d, ifid_q;

    // Branch in EX is younger than the WB write, so its target wins.
    assign redirect     = BranchTakenE | PCSrcW;
    assign redirect_tgt = BranchTakenE ? ALUResultE : ResultW;

    always_comb begin
        pc_d        = pc_q;
        align_d     = align_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (redirect) begin
            pc_d = {redirect_tgt[WIDTH-1:2], 2'b00};
            if (redirect_tgt[1:0] != 2'b00) begin
                align_d = 1'b1;
            end
        end else if (!StallF) begin
            pc_d = pc_q + WIDTH'(PC_STEP);
        end

        if (StallF && !redirect && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (FlushD && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            align_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            align_q     <= align_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ifid_d = {1'b1, pc_q + WIDTH'(PC_READ_OFFSET), InstrF};

    pipe_reg #(
        .W       (IFID_W),
        .CLR_VAL (IFID_BUBBLE)
    ) u_ifid (
        .clk   (clk),
        .rst_n (reset_n),
        .clr_i (FlushD),
        .en_i  (!StallD),
        .d_i   (ifid_d),
        .q_o   (ifid_q)
    );

    assign {ValidD, PCPlus8D, InstrD} = ifid_q;
    assign PCF      = pc_q;
    assign AlignErr = align_q;
    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] InstrF, ALUResultE, ResultW;
    logic        StallF, StallD, FlushD, BranchTakenE, PCSrcW;
    logic [31:0] PCF, InstrD, PCPlus8D;
    logic        ValidD, AlignErr;
    logic [15:0] StallCnt, FlushCnt;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_p8;
    logic        m_vld, m_align;
    int          m_sc, m_fc;

    always #5 clk = ~clk;

    fetch_stage #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .InstrF(InstrF),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .PCF(PCF), .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD),
        .AlignErr(AlignErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_p8 = 32'h0;
        m_vld = 1'b0; m_align = 1'b0; m_sc = 0; m_fc = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs currently driven.
    task automatic model_edge();
        logic        redir;
        logic [31:0] tgt, old_pc;
        old_pc = m_pc;
        redir  = BranchTakenE || PCSrcW;
        tgt    = BranchTakenE ? ALUResultE : ResultW;
        if (redir)        m_pc = (tgt / 4) * 4;
        else if (!StallF) m_pc = old_pc + 4;
        if (redir && (tgt % 4) != 0) m_align = 1'b1;
        if (StallF && !redir && m_sc < 65535) m_sc++;
        if (FlushD && m_fc < 65535) m_fc++;
        if (FlushD) begin
            m_instr = 32'h0; m_p8 = 32'h0; m_vld = 1'b0;
        end else if (!StallD) begin
            m_instr = InstrF; m_p8 = old_pc + 8; m_vld = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".PCF"},      PCF,      m_pc);
        chk({tag, ".InstrD"},   InstrD,   m_instr);
        chk({tag, ".PCPlus8D"}, PCPlus8D, m_p8);
        chk({tag, ".ValidD"},   {31'b0, ValidD},   {31'b0, m_vld});
        chk({tag, ".AlignErr"}, {31'b0, AlignErr}, {31'b0, m_align});
        chk({tag, ".StallCnt"}, {16'b0, StallCnt}, m_sc[31:0]);
        chk({tag, ".FlushCnt"}, {16'b0, FlushCnt}, m_fc[31:0]);
    endtask

    task automatic step(input string tag, input bit do_chk);
        model_edge();
        @(posedge clk);
        #1;
        if (do_chk) check_all(tag);
    endtask

    task automatic idle_inputs();
        StallF = 0; StallD = 0; FlushD = 0;
        BranchTakenE = 0; PCSrcW = 0;
        ALUResultE = 32'h0; ResultW = 32'h0;
    endtask

    initial begin
        idle_inputs();
        InstrF  = 32'hE280_1001;
        reset_n = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        chk("reset.PCF_const", PCF, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Free-running fetch
        step("run1", 1);
        chk("run1.PCF_const", PCF, 32'h4);
        chk("run1.InstrD_const", InstrD, 32'hE280_1001);
        chk("run1.P8_const", PCPlus8D, 32'h8);
        step("run2", 1);
        chk("run2.PCF_const", PCF, 32'h8);

        // Stall both PC and IF/ID at PCF=8
        StallF = 1; StallD = 1;
        step("stall1", 1);
        step("stall2", 1);
        chk("stall.PCF_const", PCF, 32'h8);
        chk("stall.cnt_const", {16'b0, StallCnt}, 32'd2);
        idle_inputs();
        step("run3", 1);

        // Taken branch with flush
        BranchTakenE = 1; ALUResultE = 32'h100; FlushD = 1;
        step("br", 1);
        chk("br.PCF_const", PCF, 32'h100);
        chk("br.ValidD_const", {31'b0, ValidD}, 32'd0);
        chk("br.FlushCnt_const", {16'b0, FlushCnt}, 32'd1);
        idle_inputs();
        step("br_next", 1);
        chk("br_next.P8_const", PCPlus8D, 32'h108);

        // Branch beats WB write, and a redirect is not counted as a stall
        BranchTakenE = 1; ALUResultE = 32'h200;
        PCSrcW = 1; ResultW = 32'h300; StallF = 1;
        step("brwb", 1);
        chk("brwb.PCF_const", PCF, 32'h200);
        chk("brwb.StallCnt_const", {16'b0, StallCnt}, 32'd2);
        idle_inputs();

        // Misaligned WB redirect sets sticky AlignErr
        PCSrcW = 1; ResultW = 32'h0000_0402;
        step("align", 1);
        chk("align.PCF_const", PCF, 32'h400);
        chk("align.err_const", {31'b0, AlignErr}, 32'd1);
        idle_inputs();
        for (int i = 0; i < 3; i++) step("align_hold", 1);

        // Asynchronous reset mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset_n = 1'b1;

        // PC wrap
        PCSrcW = 1; ResultW = 32'hFFFF_FFFC;
        step("wrap_set", 1);
        idle_inputs();
        step("wrap", 1);
        chk("wrap.PCF_const", PCF, 32'h0);
        chk("wrap.P8_const", PCPlus8D, 32'h4);

        // StallCnt saturation
        StallF = 1;
        for (int i = 0; i < 65536 + 5; i++) step("sat", 0);
        check_all("sat");
        chk("sat.StallCnt_const", {16'b0, StallCnt}, 32'h0000_FFFF);
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            InstrF       = $urandom;
            StallF       = ($urandom_range(0, 99) < 25);
            StallD       = ($urandom_range(0, 99) < 20);
            FlushD       = ($urandom_range(0, 99) < 15);
            BranchTakenE = ($urandom_range(0, 99) < 10);
            PCSrcW       = ($urandom_range(0, 99) < 10);
            ALUResultE   = $urandom;
            ResultW      = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                ALUResultE[1:0] = 2'b00;
                ResultW[1:0]    = 2'b00;
            end
            step("rand", 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
